// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: forwarding-select codes, divider sequencer states
// and the operand-forwarding priority function.
package rv_pipe_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } md_state_t;

   // Memory-stage producer is younger than Writeback, so it must win.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic [4:0] rd_m,
      input logic       reg_write_m,
      input logic [4:0] rd_w,
      input logic       reg_write_w
   );
      if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs))
         return FWD_MEM;
      else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if;
   logic [4:0] Rs1D, Rs2D;
   logic [4:0] Rs1E, Rs2E, RdE;
   logic [4:0] RdM, RdW;
   logic       RegWriteM, RegWriteW;
   logic       LoadE, PCSrcE, DivE;
   logic       StallF, StallD, StallE;
   logic       FlushD, FlushE, FlushM;
   logic [1:0] ForwardAE, ForwardBE;
   logic       MdStartE, MdValidE;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      output RegWriteM, RegWriteW, LoadE, PCSrcE, DivE,
      input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
      input  ForwardAE, ForwardBE, MdStartE, MdValidE
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      input  RegWriteM, RegWriteW, LoadE, PCSrcE, DivE,
      output StallF, StallD, StallE, FlushD, FlushE, FlushM,
      output ForwardAE, ForwardBE, MdStartE, MdValidE
   );
endinterface

// File: rtl/md_seq_fsm.sv
// Sequencer for the iterative divider: start pulse, busy window of DIV_CYCLES+1
// cycles, then a single-cycle result-valid state.
module md_seq_fsm
   import rv_pipe_pkg::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic clk,
   input  logic reset,
   input  logic DivE,
   output logic div_busy,
   output logic MdStartE,
   output logic MdValidE
);

   localparam int CNT_W = $clog2(DIV_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   md_state_t        state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      div_busy   = 1'b0;
      MdStartE   = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (DivE) begin
               MdStartE   = 1'b1;
               div_busy   = 1'b1;
               cnt_next   = CNT_LOAD;
               state_next = RUN;
            end
         end
         RUN: begin
            div_busy = 1'b1;
            cnt_next = cnt_reg - CNT_ONE;
            if (cnt_reg == CNT_ONE)
               state_next = DONE;
         end
         // The divide leaves Execute at the end of DONE, so a new start waits for IDLE.
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign MdValidE = (state_reg == DONE);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller: Execute operand forwarding, load-use stall, branch
// flush and front-end freeze while a multi-cycle divide occupies Execute.
module pipeline_hazard_ctrl
   import rv_pipe_pkg::*;
#(
   parameter int DIV_CYCLES = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   pipeline_hazard_ctrl_if.slave hz
);

   logic       div_busy;
   logic       lw_stall;
   logic [4:0] rs_e  [2];
   logic [1:0] fwd_e [2];

   assign rs_e[0] = hz.Rs1E;
   assign rs_e[1] = hz.Rs2E;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         assign fwd_e[gi] = fwd_sel(rs_e[gi], hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
      end
   endgenerate

   assign hz.ForwardAE = fwd_e[0];
   assign hz.ForwardBE = fwd_e[1];

   assign lw_stall = hz.LoadE && (hz.RdE != 5'd0) &&
                     ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

   md_seq_fsm #(
      .DIV_CYCLES (DIV_CYCLES)
   ) u_md_seq (
      .clk      (clk),
      .reset    (reset),
      .DivE     (hz.DivE),
      .div_busy (div_busy),
      .MdStartE (hz.MdStartE),
      .MdValidE (hz.MdValidE)
   );

   assign hz.StallF = lw_stall || div_busy;
   assign hz.StallD = lw_stall || div_busy;
   assign hz.StallE = div_busy;
   assign hz.FlushM = div_busy;
   assign hz.FlushD = hz.PCSrcE;
   // A held ID/EX must not also be bubbled, so the divider masks the load-use flush.
   assign hz.FlushE = (lw_stall && !div_busy) || hz.PCSrcE;

endmodule
